ili9341_fill_sequencer: RTL and testbench
=========================================

// Module: ili9341_fill_sequencer
// PURPOSE
//  Memory-mapped rectangle-fill engine for the ILI9341 8-bit parallel path. CPU programs window + RGB565 colour
//  over iomem; block emits CASET/PASET/RAMWR command+data bytes and the pixel stream to the downstream byte writer
//  via valid/ready. Frees the CPU from per-pixel bus writes; sits between the iomem bus and the LCD byte datapath.
// PARAMETERS
//  MAX_X    239  highest legal column; start rejected if x1 > MAX_X
//  MAX_Y    319  highest legal row; start rejected if y1 > MAX_Y
//  COORD_W  16   coordinate register width
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  iomem_valid  in   1   bus request
//  iomem_ready  out  1   single-cycle ack pulse
//  iomem_wstrb  in   4   nonzero = write, zero = read
//  iomem_addr   in   32  register offset in [7:0]
//  iomem_wdata  in   32  write data
//  iomem_rdata  out  32  read data, valid with iomem_ready
//  wr_valid     out  1   byte offered to byte writer
//  wr_ready     in   1   byte writer accepts (transfer = wr_valid & wr_ready)
//  wr_data      out  8   byte
//  wr_dc        out  1   1 = data, 0 = command
//  busy         out  1   fill in progress
//  irq          out  1   done interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Reset: iomem_ready=0, wr_valid=0, wr_data=0, wr_dc=0, busy=0, irq=0, state=IDLE, all regs 0. Reset mid-fill
//   aborts immediately; no further bytes offered.
//  Registers (addr[7:0]): 0x00 XWIN {x1[31:16],x0[15:0]}; 0x04 YWIN {y1,y0}; 0x08 COLOR [15:0];
//   0x0C CTRL write bit0=START; read STATUS {29'b0, err, done, busy}; 0x10 PIXLEFT read remaining pixel count.
//  Bus: request acked exactly 1 cycle after iomem_valid rises; ready never asserted two cycles in a row.
//   Writes to 0x00-0x08 while busy: acked, ignored. START while busy: acked, ignored. Unmapped: acked, rdata=0.
//  START in IDLE: if x0>x1, y0>y1, x1>MAX_X or y1>MAX_Y -> err=1, stay IDLE. Else err=0, done=0, busy=1,
//   latch window/colour, enter CASET_C.
//  FSM (each state offers one byte, advances only on transfer):
//   CASET_C 0x2A dc0 -> CASET_D x0H,x0L,x1H,x1L dc1 -> PASET_C 0x2B dc0 -> PASET_D y0H,y0L,y1H,y1L dc1
//   -> RAMWR_C 0x2C dc0 -> PIX_H colour[15:8] dc1 -> PIX_L colour[7:0] dc1 -> (more ? PIX_H : DONE)
//   DONE: 1 cycle, wr_valid=0, busy=0, done=1 -> IDLE.
//  Pixel iteration: col/row counters (no multiplier); col runs x0..x1, wraps to x0 and row++ on col==x1;
//   last pixel = col==x1 & row==y1. 1x1 window emits exactly 13 bytes. PIXLEFT = (x1-col+1)+(y1-row)*(x1-x0+1)
//   tracked as a down-counter (32 bits) loaded at START, decremented on each PIX_L transfer.
//  wr_valid, wr_data, wr_dc registered, stable while wr_valid & !wr_ready; next byte offered the cycle after a
//   transfer (sustains 1 byte/cycle when wr_ready held high). wr_valid=0 in IDLE/DONE.
//  done sticky until next accepted START; err sticky until next START.
// CONFIGURATION
//  ILI9341_FILL_IRQ_EN defined: irq = done & irq_en, irq_en = CTRL bit1 (written with any CTRL write);
//   writing CTRL bit2=1 clears done (and thus irq). Undefined: irq tied 0, CTRL bits[2:1] ignored.
// STRUCTURE
//  Package ili9341_pkg: command constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C; register offsets;
//   FSM state encoding.
//  Sub-module ili9341_rect_counter: col/row counters + PIXLEFT down-counter, last-pixel flag; FSM stays in top.
// TESTING
//  1. Window (0,0)-(0,0), colour 16'hF800, wr_ready=1 -> bytes 2A,00,00,00,00,2B,00,00,00,00,2C,F8,00; dc
//     0,1,1,1,1,0,1,1,1,1,0,1,1; done=1, busy=0 after.
//  2. Window (10,20)-(13,21), wr_ready=1 -> 8 pixels = 16 pixel bytes; PIXLEFT reads 8 at start, 0 at done.
//  3. Random wr_ready stalls -> wr_data/wr_dc stable while stalled; byte sequence identical to test 2.
//  4. START with x0=5,x1=4, then x1=240 -> err=1, no wr_valid, busy=0; valid START clears err.
//  5. Reset asserted mid-pixel stream -> next cycle wr_valid=0, busy=0, STATUS reads 0; new START runs cleanly.
//  6. ILI9341_FILL_IRQ_EN: CTRL=0x3 -> irq rises the cycle after DONE; CTRL=0x4 -> irq falls; undefined: irq=0.

Source files
------------

// File: rtl/ili9341_pkg.sv
// Shared constants for the ILI9341 rectangle-fill engine: panel commands, register map, FSM encoding,
// and a helper that picks one byte out of a CASET/PASET coordinate pair.
package ili9341_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam logic [7:0] REG_XWIN    = 8'h00;
  localparam logic [7:0] REG_YWIN    = 8'h04;
  localparam logic [7:0] REG_COLOR   = 8'h08;
  localparam logic [7:0] REG_CTRL    = 8'h0C;
  localparam logic [7:0] REG_PIXLEFT = 8'h10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CASET_C,
    ST_CASET_D,
    ST_PASET_C,
    ST_PASET_D,
    ST_RAMWR_C,
    ST_PIX_H,
    ST_PIX_L,
    ST_DONE
  } state_t;

  // Parameter bytes go out as start-high, start-low, end-high, end-low.
  function automatic logic [7:0] coord_byte(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] idx);
    case (idx)
      2'd0:    coord_byte = a[15:8];
      2'd1:    coord_byte = a[7:0];
      2'd2:    coord_byte = b[15:8];
      default: coord_byte = b[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ili9341_rect_counter.sv
// Column/row walker for the fill window plus the remaining-pixel down-counter and last-pixel flag.
module ili9341_rect_counter
  import ili9341_pkg::*;
#(
  parameter int COORD_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  output logic               last,
  output logic [31:0]        pixleft
);

  logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
  logic [31:0]        left_q, left_d;
  logic [COORD_W:0]   width, height;

  always_comb begin
    width  = {1'b0, x1} - {1'b0, x0} + (COORD_W+1)'(1);
    height = {1'b0, y1} - {1'b0, y0} + (COORD_W+1)'(1);
    col_d  = col_q;
    row_d  = row_q;
    left_d = left_q;
    if (load) begin
      col_d  = x0;
      row_d  = y0;
      // One-time product at start; iteration itself only ever adds/compares.
      left_d = 32'(width) * 32'(height);
    end else if (step) begin
      if (col_q == x1) begin
        col_d = x0;
        row_d = row_q + COORD_W'(1);
      end else begin
        col_d = col_q + COORD_W'(1);
      end
      left_d = left_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      left_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      left_q <= left_d;
    end
  end

  assign last    = (col_q == x1) && (row_q == y1);
  assign pixleft = left_q;

endmodule

// File: rtl/ili9341_fill_sequencer.sv
// iomem-mapped rectangle fill: emits CASET/PASET/RAMWR and the pixel stream to the LCD byte writer.
// Optional done interrupt enabled by defining ILI9341_FILL_IRQ_EN.
module ili9341_fill_sequencer
  import ili9341_pkg::*;
#(
  parameter int MAX_X   = 239,
  parameter int MAX_Y   = 319,
  parameter int COORD_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [7:0]  wr_data,
  output logic        wr_dc,
  output logic        busy,
  output logic        irq
);

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [15:0]        color_q, color_d;
  logic               err_q, err_d, done_q, done_d, irq_q, irq_d;
  logic               ready_q, ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               wr_valid_q, wr_valid_d, wr_dc_q, wr_dc_d;
  logic [7:0]         wr_data_q, wr_data_d;
`ifdef ILI9341_FILL_IRQ_EN
  logic               irq_en_q, irq_en_d;
`endif

  logic        acc, is_wr, is_rd, start_req, start_ok, win_bad, xfer, last, step;
  logic [7:0]  reg_addr;
  logic [31:0] pixleft;
  logic        unused_addr;

  assign unused_addr = ^iomem_addr[31:8];

  assign reg_addr  = iomem_addr[7:0];
  // Ack pulse one cycle after acceptance; a held valid is never acked on consecutive cycles.
  assign acc       = iomem_valid & ~ready_q;
  assign is_wr     = acc & (|iomem_wstrb);
  assign is_rd     = acc & ~(|iomem_wstrb);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign win_bad   = (x0_q > x1_q) || (y0_q > y1_q) ||
                     (x1_q > COORD_W'(MAX_X)) || (y1_q > COORD_W'(MAX_Y));
  assign start_req = is_wr && (reg_addr == REG_CTRL) && iomem_wdata[0] && !busy;
  assign start_ok  = start_req & ~win_bad;
  assign xfer      = wr_valid_q & wr_ready;
  assign step      = xfer && (state_q == ST_PIX_L);

  ili9341_rect_counter #(.COORD_W(COORD_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (start_ok),
    .step    (step),
    .x0      (x0_q),
    .x1      (x1_q),
    .y0      (y0_q),
    .y1      (y1_q),
    .last    (last),
    .pixleft (pixleft)
  );

  // Next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = start_ok ? ST_CASET_C : ST_IDLE;
        idx_d   = 2'd0;
      end
      ST_CASET_C: if (xfer) state_d = ST_CASET_D;
      ST_CASET_D: if (xfer) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_PASET_C;
      end
      ST_PASET_C: if (xfer) state_d = ST_PASET_D;
      ST_PASET_D: if (xfer) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_RAMWR_C;
      end
      ST_RAMWR_C: if (xfer) state_d = ST_PIX_H;
      ST_PIX_H:   if (xfer) state_d = ST_PIX_L;
      ST_PIX_L:   if (xfer) state_d = last ? ST_DONE : ST_PIX_H;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Byte for the state being entered, so a new byte is offered right after each transfer.
  always_comb begin
    wr_valid_d = 1'b1;
    wr_dc_d    = 1'b1;
    wr_data_d  = 8'h00;
    case (state_d)
      ST_CASET_C: begin wr_dc_d = 1'b0; wr_data_d = CMD_CASET; end
      ST_CASET_D: wr_data_d = coord_byte(16'(x0_q), 16'(x1_q), idx_d);
      ST_PASET_C: begin wr_dc_d = 1'b0; wr_data_d = CMD_PASET; end
      ST_PASET_D: wr_data_d = coord_byte(16'(y0_q), 16'(y1_q), idx_d);
      ST_RAMWR_C: begin wr_dc_d = 1'b0; wr_data_d = CMD_RAMWR; end
      ST_PIX_H:   wr_data_d = color_q[15:8];
      ST_PIX_L:   wr_data_d = color_q[7:0];
      default:    begin wr_valid_d = 1'b0; wr_dc_d = 1'b0; end
    endcase
  end

  // Register file and bus response
  always_comb begin
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    color_d = color_q;
    err_d   = err_q;
    done_d  = done_q;
    ready_d = acc;
    rdata_d = 32'h0;
`ifdef ILI9341_FILL_IRQ_EN
    irq_en_d = irq_en_q;
    if (is_wr && reg_addr == REG_CTRL) begin
      irq_en_d = iomem_wdata[1];
      if (iomem_wdata[2]) done_d = 1'b0;
    end
    irq_d = done_q & irq_en_q;
`else
    irq_d = 1'b0;
`endif
    if (is_wr && !busy) begin
      case (reg_addr)
        REG_XWIN:  begin x0_d = COORD_W'(iomem_wdata[15:0]); x1_d = COORD_W'(iomem_wdata[31:16]); end
        REG_YWIN:  begin y0_d = COORD_W'(iomem_wdata[15:0]); y1_d = COORD_W'(iomem_wdata[31:16]); end
        REG_COLOR: color_d = iomem_wdata[15:0];
        default:   ;
      endcase
    end
    if (start_req) err_d = win_bad;
    if (start_ok) done_d = 1'b0;
    if (step && last) done_d = 1'b1;
    if (is_rd) begin
      case (reg_addr)
        REG_XWIN:    rdata_d = {16'(x1_q), 16'(x0_q)};
        REG_YWIN:    rdata_d = {16'(y1_q), 16'(y0_q)};
        REG_COLOR:   rdata_d = {16'h0, color_q};
        REG_CTRL:    rdata_d = {29'h0, err_q, done_q, busy};
        REG_PIXLEFT: rdata_d = pixleft;
        default:     rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      color_q    <= 16'h0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'h0;
      wr_valid_q <= 1'b0;
      wr_dc_q    <= 1'b0;
      wr_data_q  <= 8'h00;
`ifdef ILI9341_FILL_IRQ_EN
      irq_en_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      color_q    <= color_d;
      err_q      <= err_d;
      done_q     <= done_d;
      irq_q      <= irq_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      wr_valid_q <= wr_valid_d;
      wr_dc_q    <= wr_dc_d;
      wr_data_q  <= wr_data_d;
`ifdef ILI9341_FILL_IRQ_EN
      irq_en_q   <= irq_en_d;
`endif
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign wr_valid    = wr_valid_q;
  assign wr_data     = wr_data_q;
  assign wr_dc       = wr_dc_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_ili9341_fill_sequencer.sv
// Directed bench for ili9341_fill_sequencer: byte streams, status/PIXLEFT, stalls, errors, reset, irq.
module tb_ili9341_fill_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [7:0]  wr_data;
  logic        wr_dc;
  logic        busy;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;
  logic       stall_mode = 1'b0;
  logic       prev_stall = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [8:0] prev_byte = 9'h0;
  logic [8:0] cap[$];
  logic [8:0] exp_q[$];
  logic [31:0] rd;

  ili9341_fill_sequencer dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_dc(wr_dc),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Negedge monitor: stall stability, ready pulse shape, byte capture, wr_ready drive.
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("stall_valid", 32'(wr_valid), 32'd1);
      chk("stall_byte", 32'({wr_dc, wr_data}), 32'(prev_byte));
    end
    if (prev_rdy) chk("ready_pulse", 32'(iomem_ready), 32'd0);
    prev_rdy = iomem_ready;
    wr_ready = stall_mode ? ($urandom_range(0, 2) == 0 ? 1'b0 : 1'b1) : 1'b1;
    prev_stall = wr_valid & ~wr_ready & ~reset;
    prev_byte = {wr_dc, wr_data};
    if (wr_valid && wr_ready && !reset) cap.push_back({wr_dc, wr_data});
  end

  task automatic bus(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r);
    int n;
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = {24'h0, a}; iomem_wdata = d; iomem_wstrb = s;
    n = 0;
    do begin @(negedge clk); n++; end while (!iomem_ready && n < 8);
    chk("bus_ack_latency", 32'(n), 32'd1);
    r = iomem_rdata;
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(a, d, 4'hF, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] want);
    logic [31:0] r;
    bus(a, 32'h0, 4'h0, r);
    chk(tag, r, want);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    chk("fill_finished_in_budget", 32'(busy), 32'd0);
  endtask

  task automatic build_exp(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] y0,
                           input logic [15:0] y1, input logic [15:0] c, input int npix);
    exp_q.delete();
    exp_q.push_back(9'h02A);
    exp_q.push_back({1'b1, x0[15:8]}); exp_q.push_back({1'b1, x0[7:0]});
    exp_q.push_back({1'b1, x1[15:8]}); exp_q.push_back({1'b1, x1[7:0]});
    exp_q.push_back(9'h02B);
    exp_q.push_back({1'b1, y0[15:8]}); exp_q.push_back({1'b1, y0[7:0]});
    exp_q.push_back({1'b1, y1[15:8]}); exp_q.push_back({1'b1, y1[7:0]});
    exp_q.push_back(9'h02C);
    for (int i = 0; i < npix; i++) begin
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_nbytes"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(exp_q[i]));
  endtask

  task automatic load_t1_exp();
    logic [8:0] t1 [13];
    t1 = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h100,
           9'h02C, 9'h1F8, 9'h100};
    exp_q.delete();
    for (int i = 0; i < 13; i++) exp_q.push_back(t1[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(iomem_ready), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_wr_dc", 32'(wr_dc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    rd_chk("rst_status", 8'h0C, 32'h0);
    rd_chk("rst_xwin", 8'h00, 32'h0);
    rd_chk("unmapped_read", 8'h40, 32'h0);
    wr(8'h44, 32'hDEAD_BEEF);

    // 1x1 window at origin, red
    wr(8'h00, 32'h0); wr(8'h04, 32'h0); wr(8'h08, 32'h0000_F800);
    rd_chk("color_rb", 8'h08, 32'h0000_F800);
    cap.delete();
    wr(8'h0C, 32'h1);
    wait_idle(200);
    load_t1_exp();
    cmp_stream("t1");
    rd_chk("t1_status", 8'h0C, 32'h2);
    chk("t1_wr_valid_idle", 32'(wr_valid), 32'd0);
`ifndef ILI9341_FILL_IRQ_EN
    chk("t1_irq_tied_low", 32'(irq), 32'd0);
`endif

    // 4x2 window, green; writes while busy must be ignored
    wr(8'h00, 32'h000D_000A); wr(8'h04, 32'h0015_0014); wr(8'h08, 32'h0000_07E0);
    cap.delete();
    wr(8'h0C, 32'h1);
    rd_chk("t2_pixleft_start", 8'h10, 32'd8);
    wr(8'h00, 32'hFFFF_FFFF);
    wr(8'h08, 32'h0000_1234);
    wait_idle(300);
    build_exp(16'd10, 16'd13, 16'd20, 16'd21, 16'h07E0, 8);
    cmp_stream("t2");
    rd_chk("t2_pixleft_done", 8'h10, 32'd0);
    rd_chk("t2_xwin_kept", 8'h00, 32'h000D_000A);
    rd_chk("t2_color_kept", 8'h08, 32'h0000_07E0);
    rd_chk("t2_status", 8'h0C, 32'h2);

    // same window under random back-pressure
    stall_mode = 1'b1;
    cap.delete();
    wr(8'h0C, 32'h1);
    wait_idle(2000);
    stall_mode = 1'b0;
    @(negedge clk);
    cmp_stream("t3");

    // far corner single pixel: x1=MAX_X, y1=MAX_Y accepted
    wr(8'h00, 32'h00EF_00EF); wr(8'h04, 32'h013F_013F); wr(8'h08, 32'h0000_ABCD);
    cap.delete();
    wr(8'h0C, 32'h1);
    wait_idle(200);
    build_exp(16'd239, 16'd239, 16'd319, 16'd319, 16'hABCD, 1);
    cmp_stream("corner");

    // rejected windows: err set, done kept, nothing emitted
    cap.delete();
    wr(8'h00, 32'h0004_0005); wr(8'h04, 32'h0);
    wr(8'h0C, 32'h1);
    chk("t4_busy_swap", 32'(busy), 32'd0);
    rd_chk("t4_status_swap", 8'h0C, 32'h6);
    wr(8'h00, 32'h00F0_0000);
    wr(8'h0C, 32'h1);
    rd_chk("t4_status_x240", 8'h0C, 32'h6);
    wr(8'h00, 32'h0); wr(8'h04, 32'h0140_0000);
    wr(8'h0C, 32'h1);
    rd_chk("t4_status_y320", 8'h0C, 32'h6);
    repeat (10) @(negedge clk);
    chk("t4_no_bytes", 32'(cap.size()), 32'd0);
    wr(8'h04, 32'h0);
    wr(8'h0C, 32'h1);
    rd_chk("t4_status_restart", 8'h0C, 32'h1);
    wait_idle(200);
    rd_chk("t4_status_done", 8'h0C, 32'h2);

    // reset mid pixel stream
    wr(8'h00, 32'h000D_000A); wr(8'h04, 32'h0015_0014);
    cap.delete();
    wr(8'h0C, 32'h1);
    for (int n = 0; n < 100 && cap.size() < 14; n++) @(negedge clk);
    chk("t5_reached_pixels", 32'(cap.size() >= 14), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_wr_valid", 32'(wr_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    rd_chk("t5_status", 8'h0C, 32'h0);
    rd_chk("t5_pixleft", 8'h10, 32'h0);
    rd_chk("t5_xwin", 8'h00, 32'h0);
    wr(8'h08, 32'h0000_F800);
    cap.delete();
    wr(8'h0C, 32'h1);
    wait_idle(200);
    load_t1_exp();
    cmp_stream("t5_restart");

`ifdef ILI9341_FILL_IRQ_EN
    wr(8'h0C, 32'h3);
    wait_idle(200);
    chk("t6_irq_in_done", 32'(irq), 32'd0);
    @(negedge clk);
    chk("t6_irq_rise", 32'(irq), 32'd1);
    wr(8'h0C, 32'h4);
    @(negedge clk);
    chk("t6_irq_fall", 32'(irq), 32'd0);
    rd_chk("t6_status_cleared", 8'h0C, 32'h0);
`else
    wr(8'h0C, 32'h3);
    wait_idle(200);
    repeat (2) @(negedge clk);
    chk("t6_irq_disabled", 32'(irq), 32'd0);
    rd_chk("t6_status", 8'h0C, 32'h2);
    wr(8'h0C, 32'h4);
    rd_chk("t6_bit2_ignored", 8'h0C, 32'h2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
